// File: rtl/palette_fx_scheduler.sv
// Frame-rate palette effects: attack palette cycling, hit flash and screen fades.
// All effect state advances once per video frame on the frame clock.
module palette_fx_scheduler #(
    parameter int CYCLE_NUM    = 9,
    parameter int CYCLE_DIV    = 2,
    parameter int FLASH_FRAMES = 8,
    parameter int FADE_STEPS   = 16,
    parameter int FADE_DIV     = 4
) (
    input  logic       game_frame_clk_rising_edge,
    input  logic       Reset,
    input  logic       attack_active,
    input  logic       hit_req,
    input  logic       fade_out_req,
    input  logic       fade_in_req,
    output logic       hit_ack,
    output logic       fade_ack,
    output logic [4:0] cycle_offset,
    output logic       flash_on,
    output logic [3:0] bright_level,
    output logic [2:0] fx_state,
    output logic       busy
);

    localparam int CD_W = (CYCLE_DIV > 1) ? $clog2(CYCLE_DIV) : 1;
    localparam int FD_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam int FC_W = (FLASH_FRAMES > 4) ? $clog2(FLASH_FRAMES) : 2;

    localparam logic [CD_W-1:0] CYCLE_DIV_LAST = CD_W'(CYCLE_DIV - 1);
    localparam logic [4:0]      CYCLE_LAST     = 5'(CYCLE_NUM - 1);
    localparam logic [FD_W-1:0] FADE_DIV_LAST  = FD_W'(FADE_DIV - 1);
    localparam logic [FC_W-1:0] FLASH_LAST     = FC_W'(FLASH_FRAMES - 1);
    localparam logic [3:0]      BRIGHT_MAX     = 4'(FADE_STEPS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLASH    = 3'd1,
        FADE_OUT = 3'd2,
        BLACK    = 3'd3,
        FADE_IN  = 3'd4
    } fx_state_t;

    fx_state_t       state_reg, state_next;
    logic [FC_W-1:0] flash_cnt_reg, flash_cnt_next;
    logic            flash_on_reg, flash_on_next;
    logic [3:0]      bright_reg, bright_next;
    logic [FD_W-1:0] fade_div_reg, fade_div_next;
    logic            hit_ack_reg, hit_ack_next;
    logic            fade_ack_reg, fade_ack_next;
    logic [CD_W-1:0] cycle_div_reg, cycle_div_next;
    logic [4:0]      cycle_offset_reg, cycle_offset_next;
    logic [FC_W-1:0] flash_cnt_inc;

    assign flash_cnt_inc = flash_cnt_reg + 1'b1;

    always_ff @(posedge game_frame_clk_rising_edge) begin
        if (Reset) begin
            state_reg        <= IDLE;
            flash_cnt_reg    <= '0;
            flash_on_reg     <= 1'b0;
            bright_reg       <= BRIGHT_MAX;
            fade_div_reg     <= '0;
            hit_ack_reg      <= 1'b0;
            fade_ack_reg     <= 1'b0;
            cycle_div_reg    <= '0;
            cycle_offset_reg <= '0;
        end else begin
            state_reg        <= state_next;
            flash_cnt_reg    <= flash_cnt_next;
            flash_on_reg     <= flash_on_next;
            bright_reg       <= bright_next;
            fade_div_reg     <= fade_div_next;
            hit_ack_reg      <= hit_ack_next;
            fade_ack_reg     <= fade_ack_next;
            cycle_div_reg    <= cycle_div_next;
            cycle_offset_reg <= cycle_offset_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        flash_cnt_next = flash_cnt_reg;
        flash_on_next  = flash_on_reg;
        bright_next    = bright_reg;
        fade_div_next  = fade_div_reg;
        hit_ack_next   = 1'b0;
        fade_ack_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                // fade_in_req is meaningless here: the screen is already at full brightness.
                if (fade_out_req) begin
                    state_next    = FADE_OUT;
                    fade_div_next = '0;
                    fade_ack_next = 1'b1;
                end else if (hit_req) begin
                    state_next     = FLASH;
                    flash_cnt_next = '0;
                    flash_on_next  = 1'b1;
                    hit_ack_next   = 1'b1;
                end
            end
            FLASH: begin
                if (fade_out_req) begin
                    state_next    = FADE_OUT;
                    flash_on_next = 1'b0;
                    fade_div_next = '0;
                    fade_ack_next = 1'b1;
                end else if (hit_req) begin
                    flash_cnt_next = '0;
                    flash_on_next  = 1'b1;
                    hit_ack_next   = 1'b1;
                end else if (flash_cnt_reg >= FLASH_LAST) begin
                    state_next     = IDLE;
                    flash_cnt_next = '0;
                    flash_on_next  = 1'b0;
                end else begin
                    // Two frames on, two frames off.
                    flash_cnt_next = flash_cnt_inc;
                    flash_on_next  = ~flash_cnt_inc[1];
                end
            end
            FADE_OUT: begin
                if (fade_div_reg >= FADE_DIV_LAST) begin
                    fade_div_next = '0;
                    if (bright_reg <= 4'd1) begin
                        bright_next = 4'd0;
                        state_next  = BLACK;
                    end else begin
                        bright_next = bright_reg - 4'd1;
                    end
                end else begin
                    fade_div_next = fade_div_reg + 1'b1;
                end
            end
            BLACK: begin
                bright_next = 4'd0;
                if (fade_in_req) begin
                    state_next    = FADE_IN;
                    fade_div_next = '0;
                    fade_ack_next = 1'b1;
                end
            end
            FADE_IN: begin
                if (fade_out_req) begin
                    state_next    = FADE_OUT;
                    fade_div_next = '0;
                    fade_ack_next = 1'b1;
                end else if (fade_div_reg >= FADE_DIV_LAST) begin
                    fade_div_next = '0;
                    if (bright_reg >= BRIGHT_MAX - 4'd1) begin
                        bright_next = BRIGHT_MAX;
                        state_next  = IDLE;
                    end else begin
                        bright_next = bright_reg + 4'd1;
                    end
                end else begin
                    fade_div_next = fade_div_reg + 1'b1;
                end
            end
            default: begin
                state_next     = IDLE;
                flash_cnt_next = '0;
                flash_on_next  = 1'b0;
                fade_div_next  = '0;
            end
        endcase
    end

    // Palette cycling runs regardless of the effect FSM, but freezes on a black screen.
    always_comb begin
        cycle_div_next    = cycle_div_reg;
        cycle_offset_next = cycle_offset_reg;
        if (!attack_active) begin
            cycle_div_next    = '0;
            cycle_offset_next = '0;
        end else if (state_reg != BLACK) begin
            if (cycle_div_reg >= CYCLE_DIV_LAST) begin
                cycle_div_next    = '0;
                cycle_offset_next = (cycle_offset_reg >= CYCLE_LAST) ? 5'd0
                                                                     : cycle_offset_reg + 5'd1;
            end else begin
                cycle_div_next = cycle_div_reg + 1'b1;
            end
        end
    end

    assign hit_ack      = hit_ack_reg;
    assign fade_ack     = fade_ack_reg;
    assign cycle_offset = cycle_offset_reg;
    assign flash_on     = flash_on_reg;
    assign bright_level = bright_reg;
    assign fx_state     = state_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_palette_fx_scheduler.sv
// Directed bench for palette_fx_scheduler: flash, fades, cycling, preemption and reset.
module tb_palette_fx_scheduler;

    logic       clk;
    logic       rst;
    logic       attack_active;
    logic       hit_req;
    logic       fade_out_req;
    logic       fade_in_req;
    logic       hit_ack;
    logic       fade_ack;
    logic [4:0] cycle_offset;
    logic       flash_on;
    logic [3:0] bright_level;
    logic [2:0] fx_state;
    logic       busy;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    palette_fx_scheduler dut (
        .game_frame_clk_rising_edge(clk),
        .Reset        (rst),
        .attack_active(attack_active),
        .hit_req      (hit_req),
        .fade_out_req (fade_out_req),
        .fade_in_req  (fade_in_req),
        .hit_ack      (hit_ack),
        .fade_ack     (fade_ack),
        .cycle_offset (cycle_offset),
        .flash_on     (flash_on),
        .bright_level (bright_level),
        .fx_state     (fx_state),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One frame: let the edge happen, then sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_state"},  fx_state, 0);
        check({tag, "_bright"}, bright_level, 15);
        check({tag, "_offset"}, cycle_offset, 0);
        check({tag, "_hitack"}, hit_ack, 0);
        check({tag, "_fadeack"}, fade_ack, 0);
        check({tag, "_flash"},  flash_on, 0);
        check({tag, "_busy"},   busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        attack_active = 1'b0;
        hit_req = 1'b0;
        fade_out_req = 1'b0;
        fade_in_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_idle_reset("reset");
        $display("txn reset_initial");

        // Hit flash from IDLE, single-frame request.
        hit_req = 1'b1;
        step();
        hit_req = 1'b0;
        check("hit_ack", hit_ack, 1);
        check("hit_state", fx_state, 1);
        check("hit_busy", busy, 1);
        check("hit_flash0", flash_on, 1);
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("hit_flash%0d", i), flash_on, ((i / 2) % 2 == 0) ? 1 : 0);
            check($sformatf("hit_ack_low%0d", i), hit_ack, 0);
        end
        step();
        check("hit_end_state", fx_state, 0);
        check("hit_end_flash", flash_on, 0);
        $display("txn hit_flash");

        // Simultaneous hit and fade-out: fade-out wins.
        hit_req = 1'b1;
        fade_out_req = 1'b1;
        step();
        hit_req = 1'b0;
        fade_out_req = 1'b0;
        check("arb_fadeack", fade_ack, 1);
        check("arb_hitack", hit_ack, 0);
        check("arb_state", fx_state, 2);
        check("arb_bright", bright_level, 15);
        for (int k = 1; k <= 60; k++) begin
            step();
            check($sformatf("fo_bright_k%0d", k), bright_level, 15 - k / 4);
            check($sformatf("fo_state_k%0d", k), fx_state, (k == 60) ? 3 : 2);
        end
        $display("txn fade_out_to_black");

        // BLACK ignores hit and fade-out requests.
        hit_req = 1'b1;
        fade_out_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("blk_hitack%0d", k), hit_ack, 0);
            check($sformatf("blk_fadeack%0d", k), fade_ack, 0);
            check($sformatf("blk_bright%0d", k), bright_level, 0);
            check($sformatf("blk_state%0d", k), fx_state, 3);
        end
        hit_req = 1'b0;
        fade_out_req = 1'b0;
        $display("txn black_ignore");

        fade_in_req = 1'b1;
        step();
        fade_in_req = 1'b0;
        check("fi_ack", fade_ack, 1);
        check("fi_state", fx_state, 4);
        check("fi_bright", bright_level, 0);
        for (int k = 1; k <= 60; k++) begin
            step();
            check($sformatf("fi_bright_k%0d", k), bright_level, k / 4);
            check($sformatf("fi_state_k%0d", k), fx_state, (k == 60) ? 0 : 4);
        end
        $display("txn fade_in_to_idle");

        // Palette cycling over 20 frames, then drop attack_active.
        attack_active = 1'b1;
        check("cyc_k0", cycle_offset, 0);
        for (int k = 1; k < 20; k++) begin
            step();
            check($sformatf("cyc_k%0d", k), cycle_offset, (k / 2) % 9);
        end
        attack_active = 1'b0;
        step();
        check("cyc_drop", cycle_offset, 0);
        $display("txn palette_cycle");

        // Reset mid-FADE_OUT at brightness 7 while cycling.
        attack_active = 1'b1;
        fade_out_req = 1'b1;
        step();
        fade_out_req = 1'b0;
        check("rmid_ack", fade_ack, 1);
        repeat (32) step();
        check("rmid_bright7", bright_level, 7);
        check("rmid_offset", cycle_offset, 33 / 2 % 9);
        rst = 1'b1;
        attack_active = 1'b0;
        step();
        rst = 1'b0;
        check_idle_reset("rmid");
        $display("txn reset_mid_fade");

        // Fade-out preempts a flash at frame 3; hit_req alongside is not acked.
        hit_req = 1'b1;
        step();
        hit_req = 1'b0;
        check("pre_hitack", hit_ack, 1);
        repeat (3) step();
        check("pre_frame3_flash", flash_on, 0);
        check("pre_frame3_state", fx_state, 1);
        hit_req = 1'b1;
        fade_out_req = 1'b1;
        step();
        hit_req = 1'b0;
        fade_out_req = 1'b0;
        check("pre_flash", flash_on, 0);
        check("pre_state", fx_state, 2);
        check("pre_fadeack", fade_ack, 1);
        check("pre_nohitack", hit_ack, 0);
        $display("txn flash_preempt");

        // Cycling runs during FADE_OUT and freezes once BLACK is reached.
        attack_active = 1'b1;
        repeat (60) step();
        check("frz_state", fx_state, 3);
        check("frz_offset_entry", cycle_offset, 3);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("frz_offset%0d", k), cycle_offset, 3);
        end
        attack_active = 1'b0;
        step();
        check("frz_drop", cycle_offset, 0);
        $display("txn black_freeze");

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule

// File: doc/palette_fx_scheduler.md
Name: palette_fx_scheduler

Overview:
- Frame-rate effect sequencer for the color mapping path.
- Generates the attack palette-cycling offset, a player-hit flash, and game-over/game-start screen fades.
- Arbitrates among the hit, fade-out and fade-in requesters.
- Outputs feed the color mapper: cycle offset into the cycled-index arithmetic, flash/brightness into the final RGB stage.

Parameters:
CYCLE_NUM, 9, number of cycling palette entries; cycle_offset wraps at CYCLE_NUM-1.
CYCLE_DIV, 2, frames per cycling step.
FLASH_FRAMES, 8, length of hit flash in frames (even, >=2).
FADE_STEPS, 16, brightness levels; max level FADE_STEPS-1 = full brightness.
FADE_DIV, 4, frames per brightness step.

Ports:
game_frame_clk_rising_edge  in  1  frame clock; one edge per video frame.
Reset  in  1  synchronous, active-high.
attack_active  in  1  attack sprite on screen; enables palette cycling.
hit_req  in  1  level request for hit flash; held until hit_ack.
fade_out_req  in  1  level request for fade to black (game over); held until fade_ack.
fade_in_req  in  1  level request for fade from black (game start); held until fade_ack.
hit_ack  out  1  one-frame pulse when hit_req is accepted.
fade_ack  out  1  one-frame pulse when either fade request is accepted.
cycle_offset  out  5  palette cycling offset, 0..CYCLE_NUM-1.
flash_on  out  1  high: mapper forces player pixels white.
bright_level  out  4  0 = black, FADE_STEPS-1 = full brightness.
fx_state  out  3  IDLE=0, FLASH=1, FADE_OUT=2, BLACK=3, FADE_IN=4.
busy  out  1  high whenever fx_state != IDLE.

Behaviour:
- Clocking and reset:
  - All state changes on posedge game_frame_clk_rising_edge.
  - Reset has priority over everything and applies on that edge.
  - Reset values: fx_state=IDLE, cycle_offset=0, cycle divider=0, flash_on=0, flash counter=0, bright_level=FADE_STEPS-1, fade divider=0, hit_ack=0, fade_ack=0, busy=0.
- Handshake:
  - Requests are sampled at each edge.
  - Acceptance transitions the state and asserts the ack on that same edge, so the ack is visible for exactly one frame, one frame after the request was sampled.
  - Requester deasserts after seeing the ack.
  - A request still high on the frame after its ack is not re-accepted in the new state, except the FLASH retrigger rule below.
- Arbitration priority: fade_out_req > fade_in_req > hit_req.
- IDLE:
  - fade_out_req -> FADE_OUT: fade divider=0, fade_ack.
  - else hit_req -> FLASH: flash counter=0, flash_on=1, hit_ack.
  - fade_in_req is ignored in IDLE (brightness already full).
- FLASH:
  - Flash counter c increments each frame.
  - flash_on = 1 when bit1 of the frame index is 0: pattern 1,1,0,0,1,1,0,0 for FLASH_FRAMES=8.
  - On the edge where c==FLASH_FRAMES-1: -> IDLE, flash_on=0.
  - hit_req in FLASH restarts the counter (c=0, flash_on=1) with hit_ack.
  - fade_out_req preempts: -> FADE_OUT, flash_on=0, fade_ack; hit_req is not acked on that edge.
- FADE_OUT:
  - Fade divider counts 0..FADE_DIV-1; at wrap, bright_level decrements by 1.
  - Decrement from 1 to 0 -> BLACK on the same edge.
  - With defaults, BLACK is reached 60 frames after acceptance.
  - All requests are ignored.
- BLACK:
  - bright_level held at 0.
  - fade_in_req -> FADE_IN: divider=0, fade_ack. All other requests ignored.
- FADE_IN:
  - Mirror of FADE_OUT: increment at each divider wrap.
  - Reaching FADE_STEPS-1 -> IDLE.
  - fade_out_req preempts: -> FADE_OUT from the current level, divider=0, fade_ack.
- Palette cycling (independent of FSM):
  - When attack_active=0: cycle_offset=0 and cycle divider=0.
  - Else the divider counts 0..CYCLE_DIV-1; at wrap, cycle_offset increments, CYCLE_NUM-1 -> 0.
  - Frozen (holds value) in BLACK.
- Arithmetic and invalid states:
  - Counters never exceed parameter bounds; bright_level saturates.
  - Illegal fx_state encodings -> IDLE next edge.

Test Plan:
- Reset mid-FADE_OUT (bright_level=7) -> next edge fx_state=0, bright_level=15, cycle_offset=0, acks 0.
- hit_req high 1 frame from IDLE -> hit_ack one frame; flash_on 1,1,0,0,1,1,0,0; fx_state=IDLE and flash_on=0 after frame 8.
- hit_req and fade_out_req together in IDLE -> only fade_ack; fx_state=2; bright_level 15->0 stepping every 4 frames; BLACK at frame 60.
- In BLACK, hit_req and fade_out_req held 10 frames -> no acks, bright_level=0. Then fade_in_req -> fade_ack, bright_level reaches 15 at frame 60, then IDLE.
- attack_active high 20 frames -> cycle_offset 0,0,1,1,...,8,8,0,0. Drop attack_active -> offset 0 next edge.
- fade_out_req during FLASH (frame 3) -> flash_on=0, fx_state=2, fade_ack, hit flash abandoned.
